// File: rtl/regfile_wb_scoreboard_pkg.sv
// Shared constants for the register file / write-back scoreboard slice.
// Also used by the destination-select mux (RA_REG) in the wider core.
package regfile_wb_scoreboard_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int CW   = 2;

  localparam logic [CW-1:0] CW_MAX   = '1;
  localparam logic [AW-1:0] ZERO_REG = 5'd0;
  localparam logic [AW-1:0] RA_REG   = 5'd31;

endpackage

// File: rtl/regfile_wb_scoreboard_pend_counter.sv
// One pending-write counter: saturating up/down, with an overflow pulse
// when an issue hits a counter that is already at CW_MAX.
module regfile_wb_scoreboard_pend_counter
  import regfile_wb_scoreboard_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          ovf
);

  // Simultaneous inc and dec cancel, so only a net increment can overflow.
  assign ovf = inc && !dec && (cnt == CW_MAX);

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc && !dec && cnt != CW_MAX) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_scoreboard.sv
// Register file with write-first bypass and a per-register pending-write
// scoreboard that stalls decode on operands whose producer is in flight.
module regfile_wb_scoreboard
  import regfile_wb_scoreboard_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [AW-1:0]      ra1,
  input  logic [AW-1:0]      ra2,
  output logic [DW-1:0]      rd1,
  output logic [DW-1:0]      rd2,
  input  logic               use1,
  input  logic               use2,
  input  logic               issue_en,
  input  logic [AW-1:0]      issue_wa,
  input  logic               we,
  input  logic [AW-1:0]      wa,
  input  logic [DW-1:0]      wd,
  output logic               stall,
  output logic               ovf_err,
  output logic [NREG*CW-1:0] pend_cnt
);

  logic [DW-1:0]            regs [NREG];
  logic [NREG-1:0][CW-1:0]  cnt;
  logic [NREG-1:0]          ovf_vec;
  logic                     wb_valid;
  logic                     pend1;
  logic                     pend2;

  assign wb_valid = we && (wa != ZERO_REG);

  // NOTE: the array is cleared on reset because reads after reset must
  // return zero; without that requirement it would be left unreset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_valid) begin
      regs[wa] <= wd;
    end
  end

  // Write-first read ports; register 0 never reaches the array output.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != ZERO_REG) rd1 = (we && wa == ra1) ? wd : regs[ra1];
    if (ra2 != ZERO_REG) rd2 = (we && wa == ra2) ? wd : regs[ra2];
  end

  assign cnt[0]     = '0;
  assign ovf_vec[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_cnt
    regfile_wb_scoreboard_pend_counter u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (issue_en && issue_wa == AW'(i)),
      .dec   (we && wa == AW'(i)),
      .cnt   (cnt[i]),
      .ovf   (ovf_vec[i])
    );
  end

  assign pend_cnt = cnt;

  // A lone outstanding writer retiring this cycle is covered by the bypass.
  always_comb begin
    pend1 = use1 && (ra1 != ZERO_REG) && (cnt[ra1] != '0) &&
            !((cnt[ra1] == CW'(1)) && we && (wa == ra1));
    pend2 = use2 && (ra2 != ZERO_REG) && (cnt[ra2] != '0) &&
            !((cnt[ra2] == CW'(1)) && we && (wa == ra2));
    stall = pend1 | pend2;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_err <= 1'b0;
    end else if (|ovf_vec) begin
      ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Directed bench for regfile_wb_scoreboard: scoreboarded write/readback plus
// an independent counter model checked after every clock edge.
module tb_regfile_wb_scoreboard;
  import regfile_wb_scoreboard_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [AW-1:0]      ra1 = '0, ra2 = '0;
  logic [DW-1:0]      rd1, rd2;
  logic               use1 = 1'b0, use2 = 1'b0;
  logic               issue_en = 1'b0;
  logic [AW-1:0]      issue_wa = '0;
  logic               we = 1'b0;
  logic [AW-1:0]      wa = '0;
  logic [DW-1:0]      wd = '0;
  logic               stall, ovf_err;
  logic [NREG*CW-1:0] pend_cnt;

  regfile_wb_scoreboard dut (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .use1(use1), .use2(use2), .issue_en(issue_en), .issue_wa(issue_wa),
    .we(we), .wa(wa), .wd(wd), .stall(stall), .ovf_err(ovf_err),
    .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t sb[$];
  int  n_vec = 0;
  int  n_miss = 0;
  int  model_cnt [NREG];
  bit  model_ovf = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREG*CW-1:0] model_flat();
    logic [NREG*CW-1:0] v = '0;
    for (int r = 0; r < NREG; r++) v[r*CW +: CW] = model_cnt[r][CW-1:0];
    return v;
  endfunction

  // Advance the counter model from the driven inputs, clock, then compare.
  task automatic tick();
    for (int r = 1; r < NREG; r++) begin
      bit inc = issue_en && (int'(issue_wa) == r);
      bit dec = we && (int'(wa) == r);
      if (inc && !dec) begin
        if (model_cnt[r] == (1 << CW) - 1) model_ovf = 1'b1;
        else model_cnt[r]++;
      end else if (dec && !inc && model_cnt[r] > 0) begin
        model_cnt[r]--;
      end
    end
    @(posedge clk);
    #1;
    check("pend_cnt", 64'(pend_cnt), 64'(model_flat()));
    check("ovf_err", 64'(ovf_err), 64'(model_ovf));
  endtask

  initial begin
    wr_t e;
    for (int r = 0; r < NREG; r++) model_cnt[r] = 0;

    // 1. reset state: every address reads zero, nothing pending
    #1 reset = 1'b1;
    #10 reset = 1'b0;
    use1 = 1'b1;
    use2 = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      ra1 = AW'(i);
      ra2 = AW'(NREG - 1 - i);
      #1;
      check("reset_rd1", 64'(rd1), 64'd0);
      check("reset_rd2", 64'(rd2), 64'd0);
      check("reset_stall", 64'(stall), 64'd0);
    end
    check("reset_ovf", 64'(ovf_err), 64'd0);
    check("reset_pend", 64'(pend_cnt), 64'd0);
    use1 = 1'b0;
    use2 = 1'b0;
    tick();

    // 2. bypass in the write cycle, then stored value after the edge
    we = 1'b1; wa = 5'd8; wd = 32'hDEADBEEF; ra1 = 5'd8;
    #1 check("bypass_rd1", 64'(rd1), 64'hDEADBEEF);
    sb.push_back('{addr: 5'd8, data: 32'hDEADBEEF});
    tick();
    we = 1'b0;
    e = sb.pop_front();
    ra1 = e.addr;
    #1 check("stored_rd1", 64'(rd1), 64'(e.data));

    we = 1'b1; wa = 5'd0; wd = 32'h1234; ra2 = 5'd0;
    #1 check("r0_bypass_rd2", 64'(rd2), 64'd0);
    tick();
    we = 1'b0;
    #1 check("r0_rd2", 64'(rd2), 64'd0);

    // scoreboarded writes to distinct registers, read back through port 2
    for (int k = 0; k < 8; k++) begin
      we = 1'b1;
      wa = AW'(10 + k);
      wd = $urandom;
      sb.push_back('{addr: wa, data: wd});
      tick();
    end
    we = 1'b0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      ra2 = e.addr;
      #1 check("readback_rd2", 64'(rd2), 64'(e.data));
    end

    // 3. single outstanding writer on r5
    issue_en = 1'b1; issue_wa = 5'd5;
    tick();
    issue_en = 1'b0;
    ra1 = 5'd5; use1 = 1'b1;
    #1 check("r5_stall_a", 64'(stall), 64'd1);
    tick();
    check("r5_stall_b", 64'(stall), 64'd1);
    we = 1'b1; wa = 5'd5; wd = 32'hA5A50005;
    #1 check("r5_wb_stall", 64'(stall), 64'd0);
    check("r5_wb_rd1", 64'(rd1), 64'hA5A50005);
    tick();
    we = 1'b0;
    #1 check("r5_after_stall", 64'(stall), 64'd0);
    use1 = 1'b0;

    // 4. two writers on r9: first write-back still stalls
    issue_en = 1'b1; issue_wa = 5'd9;
    tick();
    tick();
    issue_en = 1'b0;
    ra2 = 5'd9; use2 = 1'b1; we = 1'b1; wa = 5'd9; wd = 32'h0000_0009;
    #1 check("r9_cnt2_stall", 64'(stall), 64'd1);
    tick();
    wd = 32'h0000_0099;
    #1 check("r9_cnt1_stall", 64'(stall), 64'd0);
    tick();
    we = 1'b0; use2 = 1'b0;

    // 5. issue and write-back to r7 in the same cycle
    issue_en = 1'b1; issue_wa = 5'd7;
    tick();
    we = 1'b1; wa = 5'd7; wd = 32'h7777_0007; ra1 = 5'd7; use1 = 1'b1;
    #1 check("r7_same_stall", 64'(stall), 64'd0);
    tick();
    issue_en = 1'b0; we = 1'b0;
    #1 check("r7_next_stall", 64'(stall), 64'd1);
    we = 1'b1;
    tick();
    we = 1'b0; use1 = 1'b0;

    // 6. saturate r3, check stickiness, then asynchronous reset
    issue_en = 1'b1; issue_wa = 5'd3;
    tick();
    tick();
    tick();
    check("r3_cnt3", 64'(pend_cnt[3*CW +: CW]), 64'd3);
    check("r3_no_ovf_yet", 64'(ovf_err), 64'd0);
    tick();
    check("r3_sat_cnt", 64'(pend_cnt[3*CW +: CW]), 64'd3);
    check("r3_ovf", 64'(ovf_err), 64'd1);
    issue_en = 1'b0;
    tick();
    check("ovf_sticky", 64'(ovf_err), 64'd1);
    ra1 = 5'd8;
    #3 reset = 1'b1;
    #1;
    check("async_ovf", 64'(ovf_err), 64'd0);
    check("async_pend", 64'(pend_cnt), 64'd0);
    check("async_rd1", 64'(rd1), 64'd0);
    #1 reset = 1'b0;
    for (int r = 0; r < NREG; r++) model_cnt[r] = 0;
    model_ovf = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scoreboard.md
Name: regfile_wb_scoreboard

Overview:
- Register-file endpoint for the write-back path: consumes the write address and write data produced by the destination-select and write-back-data muxes.
- Provides two combinational read ports to decode, with same-cycle write-to-read bypass.
- Adds a per-register pending-write scoreboard so decode can stall on operands whose producer has not yet written back.
- Sits between the decode stage (read/issue side) and the write-back stage (write side) of the pipelined MIPS core.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- AW, 5, register address width; must equal clog2(NREG).
- DW, 32, data width.
- CW, 2, width of each pending-write counter; maximum CW_MAX = 2^CW - 1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- ra1  in  AW  read address 1 (rs)
- ra2  in  AW  read address 2 (rt)
- rd1  out  DW  read data 1
- rd2  out  DW  read data 2
- use1  in  1  decode actually consumes ra1 this cycle
- use2  in  1  decode actually consumes ra2 this cycle
- issue_en  in  1  instruction with a register destination leaves decode this cycle
- issue_wa  in  AW  destination of the issuing instruction
- we  in  1  write-back write enable
- wa  in  AW  write-back address
- wd  in  DW  write-back data
- stall  out  1  decode must hold (operand pending)
- ovf_err  out  1  sticky: issue attempted on a saturated counter
- pend_cnt  out  NREG*CW  flattened counter vector, for debug and bench use

Behaviour:
Reset:
- Asynchronous. All registers are 0, all counters are 0, ovf_err = 0.
- rd1 and rd2 reflect the cleared array, so they read 0. stall = 0.
- Reset mid-operation discards pending writes and counters immediately.

Write:
- On a rising edge with we = 1 and wa != 0, reg[wa] <= wd.
- A write to address 0 is dropped. Register 0 always reads 0.

Read, combinational, zero latency:
- rdN = 0 if raN == 0.
- Otherwise rdN = wd if (we && wa == raN), else reg[raN].
- The bypass gives write-first semantics within a cycle.

Scoreboard, one CW-bit counter per register, counter 0 tied to 0:
- Increment on issue: issue_en && issue_wa != 0.
- Decrement on write-back: we && wa != 0.
- Same address incremented and decremented in the same cycle: counter is unchanged.
- Different addresses: each counter updates independently.
- Decrement of a counter already at 0 leaves it at 0. No error is raised for this case (write-back of untracked writers is allowed).
- Increment of a counter at CW_MAX leaves the counter unchanged and sets ovf_err, which stays set until reset.
- issue_en is not gated by stall inside this block. Decode must deassert issue_en while stall = 1.

Stall, combinational:
- pendN = use1/use2 && raN != 0 && cnt[raN] != 0, with the exception below.
- Exception: pendN is 0 if cnt[raN] == 1 && we && wa == raN, because the bypass satisfies it.
- stall = pend1 | pend2.
- A count of 2 or more with a matching write-back still stalls, since a younger writer is outstanding.
- issue_en in the same cycle does not affect stall. The new count is visible the next cycle.

Timing:
- Read and stall paths are combinational from the inputs and the state.
- State updates occur only on the clock edge.

Decomposition:
- Shared package: NREG, AW, DW, the register-0 constant (ZERO_REG = 0), and the link-register constant (RA_REG = 31) also used by the destination-select mux.
- One natural sub-module, pend_counter: a single CW-bit up/down saturating counter with inc, dec, and an ovf pulse, instantiated for indices 1 through NREG-1.
- The storage array and the bypass stay in the top module.

Test Plan:
1. Reset, then read all addresses with ra1 = ra2 = 0..31 → rd1 = rd2 = 0, stall = 0, ovf_err = 0, pend_cnt = 0.
2. we = 1, wa = 8, wd = 0xDEADBEEF, with ra1 = 8 in the same cycle → rd1 = 0xDEADBEEF (bypass) in the same cycle, and still 0xDEADBEEF after the edge with we = 0. A write of wa = 0, wd = 0x1234 followed by ra2 = 0 → rd2 = 0.
3. Issue to issue_wa = 5, next cycle ra1 = 5, use1 = 1 → stall = 1. Two cycles later we = 1, wa = 5 → stall = 0 in that cycle, cnt[5] = 0 after the edge.
4. Issue to register 9 twice, then one write-back to 9 with ra2 = 9, use2 = 1 → stall = 1 (cnt = 2). After the edge cnt = 1. A second write-back → stall = 0.
5. Same cycle: issue_wa = 7, we = 1, wa = 7 with cnt[7] = 1 → cnt[7] stays 1. use1 = 1, ra1 = 7 → stall = 0 in that cycle, 1 in the next.
6. Four issues to register 3 with CW = 2 → cnt[3] = 3 and ovf_err = 1 after the fourth. Then assert reset asynchronously between edges → ovf_err = 0 and cnt[3] = 0 immediately, without waiting for a clock edge.
